// File: rtl/rr_arbiter_pkg.sv
// rr_arbiter_pkg: shared FSM state type and one-hot helper for the round-robin arbiter
package rr_arbiter_pkg;
   localparam int MAX_SEL_BITS = 8;
   localparam int MAX_N = 1 << MAX_SEL_BITS;
   typedef enum logic {IDLE, BUSY} arb_state_t;
   function automatic logic [MAX_N-1:0] onehot(input logic [MAX_SEL_BITS-1:0] sel);
      return {{(MAX_N-1){1'b0}}, 1'b1} << sel;
   endfunction
endpackage

// File: rtl/rr_arbiter_pick.sv
// rr_pick: combinational round-robin search starting just above the pointer, wrapping modulo N
module rr_pick #(
   parameter int sel_bits = 2
) (
   input  logic [(1<<sel_bits)-1:0] req_i,
   input  logic [sel_bits-1:0]      ptr_i,
   output logic                     found_o,
   output logic [sel_bits-1:0]      idx_o
);
   localparam int N = 1 << sel_bits;
   localparam int W = sel_bits + 1;
   logic [2*N-1:0] dbl;
   logic [W-1:0]   pos;
   assign dbl = {req_i, req_i};
   // scan the doubled vector from farthest to nearest so the nearest hit above the pointer wins
   always_comb begin
      found_o = 1'b0;
      idx_o   = ptr_i;
      pos     = '0;
      for (int i = N; i >= 1; i--) begin
         pos = {1'b0, ptr_i} + W'(i);
         if (dbl[pos]) begin
            found_o = 1'b1;
            idx_o   = pos[sel_bits-1:0];
         end
      end
   end
endmodule

// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin arbiter with registered sel/grant, valid/ready hold and one-cycle ack; ARB_LOCK_EN adds burst lock
module rr_arbiter
   import rr_arbiter_pkg::*;
#(
   parameter int sel_bits = 2
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [(1<<sel_bits)-1:0] req_i,
   input  logic                     ready_i,
`ifdef ARB_LOCK_EN
   input  logic [(1<<sel_bits)-1:0] lock_i,
`endif
   output logic [sel_bits-1:0]      sel_o,
   output logic [(1<<sel_bits)-1:0] grant_o,
   output logic                     valid_o,
   output logic [(1<<sel_bits)-1:0] ack_o
);
   localparam int N = 1 << sel_bits;
   arb_state_t          state_q, state_d;
   logic [sel_bits-1:0] sel_q, sel_d, ptr_q, ptr_d, pick_idx, pick_ptr;
   logic [N-1:0]        grant_q, grant_d, pick_req;
   logic                pick_found, accept, keep;
   assign accept = state_q == BUSY && ready_i;
`ifdef ARB_LOCK_EN
   assign keep = accept && lock_i[sel_q];
`else
   assign keep = 1'b0;
`endif
   assign pick_req = state_q == BUSY ? req_i & ~grant_q : req_i;
   assign pick_ptr = state_q == BUSY ? sel_q : ptr_q;
   rr_pick #(.sel_bits(sel_bits)) u_pick (
      .req_i  (pick_req),
      .ptr_i  (pick_ptr),
      .found_o(pick_found),
      .idx_o  (pick_idx)
   );
   // state, winner and pointer registers; pointer starts at N-1 so requester 0 wins first
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         sel_q   <= '0;
         grant_q <= '0;
         ptr_q   <= sel_bits'(N - 1);
      end else begin
         state_q <= state_d;
         sel_q   <= sel_d;
         grant_q <= grant_d;
         ptr_q   <= ptr_d;
      end
   end
   // arbitrate from IDLE on any request, or re-arbitrate on an unlocked accept
   always_comb begin
      state_d = state_q;
      sel_d   = sel_q;
      grant_d = grant_q;
      ptr_d   = ptr_q;
      if ((state_q == IDLE && pick_found) || (accept && !keep)) begin
         ptr_d   = state_q == BUSY ? sel_q : ptr_q;
         state_d = pick_found ? BUSY : IDLE;
         sel_d   = pick_found ? pick_idx : sel_q;
         grant_d = pick_found ? N'(onehot(MAX_SEL_BITS'(pick_idx))) : '0;
      end
   end
   // outputs: registered sel/grant, valid from state, ack pulses on accept
   always_comb begin
      valid_o = state_q == BUSY;
      sel_o   = sel_q;
      grant_o = grant_q;
      ack_o   = grant_q & {N{state_q == BUSY && ready_i}};
   end
endmodule
